// File: rtl/shared_port_scheduler_4_if.sv
`timescale 1ns/1ps
// Handshake bundle between the requester engines and the shared-port scheduler.
// The scheduler uses the slave view; the requester/bench side uses the master view.
interface shared_port_scheduler_4_if #(
  parameter int LEN_W = 4
);
  logic [3:0]         req;
  logic [4*LEN_W-1:0] req_len;
  logic               beat_valid;
  logic               port_ready;
  logic [3:0]         grant;
  logic [1:0]         cur_id;
  logic               busy;
  logic [LEN_W-1:0]   beat_cnt;
  logic [3:0]         done;
  logic               timeout_err;

  modport slave (
    input  req, req_len, beat_valid, port_ready,
    output grant, cur_id, busy, beat_cnt, done, timeout_err
  );

  modport master (
    output req, req_len, beat_valid, port_ready,
    input  grant, cur_id, busy, beat_cnt, done, timeout_err
  );
endinterface

// File: rtl/shared_port_scheduler_4.sv
`timescale 1ns/1ps
// Four-way round-robin burst scheduler for one shared port: grants a requester,
// holds the grant for len+1 accepted beats or until a stall timeout, then rotates.
module shared_port_scheduler_4 #(
  parameter int LEN_W     = 4,
  parameter int TO_CYCLES = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  shared_port_scheduler_4_if.slave bus
);

  localparam int SW = $clog2(TO_CYCLES);
  localparam logic [SW-1:0] STALL_MAX = SW'(TO_CYCLES - 1);

  typedef enum logic {
    S_IDLE,
    S_XFER
  } state_t;

  state_t           r_state, w_state_next;
  logic [1:0]       r_ptr, w_ptr_next;
  logic [1:0]       r_cur_id, w_cur_id_next;
  logic [3:0]       r_grant, w_grant_next;
  logic [3:0]       r_done, w_done_next;
  logic             r_busy, w_busy_next;
  logic             r_timeout, w_timeout_next;
  logic [LEN_W-1:0] r_len, w_len_next;
  logic [LEN_W-1:0] r_beat_cnt, w_beat_cnt_next;
  logic [SW-1:0]    r_stall, w_stall_next;

  logic [1:0]       w_idx [4];
  logic [3:0]       w_rot_req;
  logic [LEN_W-1:0] w_len_arr [4];
  logic [1:0]       w_off;
  logic [1:0]       w_winner;
  logic             w_any;
  logic             w_accept;
  logic             w_last;
  logic [1:0]       w_ptr_after;

  // Rotate the request vector so that offset 0 is the current priority holder.
  for (genvar gi = 0; gi < 4; gi++) begin : g_rot
    assign w_idx[gi]     = r_ptr + 2'(gi);
    assign w_rot_req[gi] = bus.req[w_idx[gi]];
    assign w_len_arr[gi] = bus.req_len[gi*LEN_W +: LEN_W];
  end

  always_comb begin
    w_off = 2'd3;
    if (w_rot_req[0])      w_off = 2'd0;
    else if (w_rot_req[1]) w_off = 2'd1;
    else if (w_rot_req[2]) w_off = 2'd2;
  end

  assign w_any       = |bus.req;
  assign w_winner    = r_ptr + w_off;
  assign w_accept    = (r_state == S_XFER) && bus.beat_valid && bus.port_ready;
  assign w_last      = (r_beat_cnt == r_len);
  assign w_ptr_after = r_cur_id + 2'd1;

  always_comb begin
    w_state_next    = r_state;
    w_ptr_next      = r_ptr;
    w_cur_id_next   = r_cur_id;
    w_grant_next    = r_grant;
    w_busy_next     = r_busy;
    w_len_next      = r_len;
    w_beat_cnt_next = r_beat_cnt;
    w_stall_next    = r_stall;
    w_done_next     = 4'b0000;
    w_timeout_next  = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (w_any) begin
          w_state_next    = S_XFER;
          w_grant_next    = 4'b0001 << w_winner;
          w_busy_next     = 1'b1;
          w_cur_id_next   = w_winner;
          w_len_next      = w_len_arr[w_winner];
          w_beat_cnt_next = '0;
          w_stall_next    = '0;
        end
      end
      S_XFER: begin
        // An accepted beat clears the stall count, so it always beats the timeout.
        if (w_accept) begin
          w_stall_next = '0;
          if (w_last) begin
            w_state_next    = S_IDLE;
            w_done_next     = r_grant;
            w_grant_next    = 4'b0000;
            w_busy_next     = 1'b0;
            w_beat_cnt_next = '0;
            w_ptr_next      = w_ptr_after;
          end else begin
            w_beat_cnt_next = r_beat_cnt + LEN_W'(1);
          end
        end else if (r_stall == STALL_MAX) begin
          w_state_next    = S_IDLE;
          w_timeout_next  = 1'b1;
          w_grant_next    = 4'b0000;
          w_busy_next     = 1'b0;
          w_beat_cnt_next = '0;
          w_stall_next    = '0;
          w_ptr_next      = w_ptr_after;
        end else begin
          w_stall_next = r_stall + SW'(1);
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_ptr      <= 2'd0;
      r_cur_id   <= 2'd0;
      r_grant    <= 4'b0000;
      r_busy     <= 1'b0;
      r_len      <= '0;
      r_beat_cnt <= '0;
      r_stall    <= '0;
      r_done     <= 4'b0000;
      r_timeout  <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_ptr      <= w_ptr_next;
      r_cur_id   <= w_cur_id_next;
      r_grant    <= w_grant_next;
      r_busy     <= w_busy_next;
      r_len      <= w_len_next;
      r_beat_cnt <= w_beat_cnt_next;
      r_stall    <= w_stall_next;
      r_done     <= w_done_next;
      r_timeout  <= w_timeout_next;
    end
  end

  assign bus.grant       = r_grant;
  assign bus.cur_id      = r_cur_id;
  assign bus.busy        = r_busy;
  assign bus.beat_cnt    = r_beat_cnt;
  assign bus.done        = r_done;
  assign bus.timeout_err = r_timeout;

endmodule

// File: tb/tb_shared_port_scheduler_4.sv
`timescale 1ns/1ps
// Directed and random stimulus for the shared-port scheduler, checked every cycle
// against a burst-level reference model (owner, rotate pointer, beat and stall counts).
module tb_shared_port_scheduler_4;
  localparam int LEN_W = 4;
  localparam int TO    = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  shared_port_scheduler_4_if #(.LEN_W(LEN_W)) bus ();

  shared_port_scheduler_4 #(.LEN_W(LEN_W), .TO_CYCLES(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Reference model: owner = -1 means no burst in progress.
  int         m_owner, m_ptr, m_len, m_cnt, m_stall, m_cur;
  logic [3:0] m_done;
  logic       m_to;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("grant",       32'(bus.grant),       (m_owner < 0) ? 32'd0 : (32'd1 << m_owner));
    chk("cur_id",      32'(bus.cur_id),      32'(m_cur));
    chk("busy",        32'(bus.busy),        (m_owner < 0) ? 32'd0 : 32'd1);
    chk("beat_cnt",    32'(bus.beat_cnt),    32'(m_cnt));
    chk("done",        32'(bus.done),        32'(m_done));
    chk("timeout_err", 32'(bus.timeout_err), 32'(m_to));
  endtask

  task automatic model_reset();
    m_owner = -1; m_ptr = 0; m_len = 0; m_cnt = 0; m_stall = 0; m_cur = 0;
    m_done  = 4'b0000; m_to = 1'b0;
  endtask

  task automatic model_step();
    int w;
    m_done = 4'b0000;
    m_to   = 1'b0;
    if (m_owner < 0) begin
      if (bus.req != 4'b0000) begin
        w = -1;
        for (int k = 0; k < 4; k++)
          if (w < 0 && bus.req[(m_ptr + k) % 4]) w = (m_ptr + k) % 4;
        m_owner = w; m_cur = w; m_cnt = 0; m_stall = 0;
        m_len   = int'(bus.req_len[w*LEN_W +: LEN_W]);
      end
    end else if (bus.beat_valid && bus.port_ready) begin
      m_stall = 0;
      if (m_cnt == m_len) begin
        $display("txn done    owner=%0d beats=%0d cyc=%0d", m_owner, m_len + 1, cyc);
        m_done  = 4'(1 << m_owner);
        m_ptr   = (m_owner + 1) % 4;
        m_owner = -1;
        m_cnt   = 0;
      end else begin
        m_cnt++;
      end
    end else if (m_stall == TO - 1) begin
      $display("txn timeout owner=%0d beats_accepted=%0d cyc=%0d", m_owner, m_cnt, cyc);
      m_to    = 1'b1;
      m_ptr   = (m_owner + 1) % 4;
      m_owner = -1;
      m_cnt   = 0;
      m_stall = 0;
    end else begin
      m_stall++;
    end
  endtask

  task automatic drive(input logic [3:0] r, input logic [15:0] lens, input logic v, input logic rd);
    bus.req        = r;
    bus.req_len    = lens;
    bus.beat_valid = v;
    bus.port_ready = rd;
  endtask

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      if (rst) model_reset();
      else model_step();
      #1;
      check_all();
      cyc++;
    end
  endtask

  initial begin
    rst = 1'b1;
    drive(4'b0000, 16'h0000, 1'b0, 1'b0);
    model_reset();
    #1;
    check_all();
    step(2);
    rst = 1'b0;

    // 1: single requester, 4-beat burst, then rotation to requester 1
    drive(4'b0001, 16'h0003, 1'b1, 1'b1);
    step(1);
    drive(4'b0000, 16'h0003, 1'b1, 1'b1);
    step(5);
    drive(4'b1111, 16'h0000, 1'b1, 1'b1);
    step(1);

    // 2: all request, single-beat bursts rotate with a gap cycle each
    step(10);
    drive(4'b0000, 16'h0000, 1'b1, 1'b1);
    step(3);

    // 3: requester 2 burst, then 1011 -> 3 then 0; then 2 back-to-back
    drive(4'b0100, 16'h0000, 1'b1, 1'b1);
    step(2);
    drive(4'b1011, 16'h0000, 1'b1, 1'b1);
    step(4);
    drive(4'b0100, 16'h0000, 1'b1, 1'b1);
    step(6);
    drive(4'b0000, 16'h0000, 1'b1, 1'b1);
    step(2);

    // 4: stall for 5 cycles, then for TO-1 cycles, without timing out
    drive(4'b0001, 16'h2222, 1'b1, 1'b1);
    step(2);
    drive(4'b0000, 16'hFFFF, 1'b1, 1'b0);
    step(5);
    drive(4'b0000, 16'hFFFF, 1'b1, 1'b1);
    step(1);
    drive(4'b0000, 16'hFFFF, 1'b0, 1'b1);
    step(TO - 1);
    drive(4'b0000, 16'hFFFF, 1'b1, 1'b1);
    step(3);

    // 5: requester 1 never supplies beats -> timeout, next arbitration from 2
    drive(4'b0010, 16'h0050, 1'b0, 1'b1);
    step(1);
    drive(4'b0000, 16'h0050, 1'b0, 1'b1);
    step(TO + 1);
    drive(4'b1111, 16'h0000, 1'b1, 1'b1);
    step(2);

    // 6: async reset between edges mid-burst
    drive(4'b1111, 16'hFFFF, 1'b1, 1'b1);
    step(4);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_all();
    step(1);
    rst = 1'b0;
    step(2);

    // Random traffic with alternating well-behaved and stalling phases
    for (int i = 0; i < 800; i++) begin
      logic [3:0]  r;
      logic [15:0] l;
      logic        v, rd;
      r  = 4'($urandom);
      if ($urandom_range(0, 3) == 0) r = 4'b0000;
      l  = 16'($urandom) & 16'h3333;
      if (((i / 50) % 3) == 2) v = ($urandom_range(0, 9) == 0);
      else v = ($urandom_range(0, 3) != 0);
      rd = ($urandom_range(0, 4) != 0);
      drive(r, l, v, rd);
      step(1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
